// File: rtl/ps2_pkg.sv
// Shared PS/2 receive definitions: frame FSM encoding, byte width and frame parity check.
package ps2_pkg;

  localparam int PS2_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  // PS/2 uses odd parity over the 8 data bits plus the parity bit.
  function automatic logic frame_parity_ok(input logic [PS2_DATA_W-1:0] dat, input logic par);
    return ^{dat, par};
  endfunction

endpackage

// File: rtl/ps2_rx_fifo_if.sv
// Register-bus side of the PS/2 receiver: FIFO pop handshake, level, shift strobe and error flags.
interface ps2_rx_fifo_if #(
  parameter int FIFO_AW = 4
);
  import ps2_pkg::*;

  logic                  done;
  logic                  rdy;
  logic [PS2_DATA_W-1:0] data;
  logic [FIFO_AW:0]      level;
  logic                  shift;
  logic                  clr_err;
  logic                  par_err;
  logic                  frm_err;
  logic                  ovf;

  modport slave (
    input  done, clr_err,
    output rdy, data, level, shift, par_err, frm_err, ovf
  );

  modport master (
    output done, clr_err,
    input  rdy, data, level, shift, par_err, frm_err, ovf
  );

endinterface

// File: rtl/ps2_sync_filter.sv
// PS2C/PS2D synchroniser, PS2C glitch filter and falling-edge strobe.
// Pin-to-shift latency is SYNC_STAGES+FILTER_LEN+1 clocks; dat is the synchronised PS2D level.
module ps2_sync_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2c,
  input  logic ps2d,
  output logic dat,
  output logic shift
);

  localparam int CNT_W = $clog2(FILTER_LEN + 1);

  logic [SYNC_STAGES-1:0] c_sync_q, c_sync_d;
  logic [SYNC_STAGES-1:0] d_sync_q, d_sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   filt_q, filt_d;
  logic                   filt_prev_q, filt_prev_d;
  logic                   shift_q, shift_d;
  logic                   c_sync;

  assign c_sync = c_sync_q[SYNC_STAGES-1];

  always_comb begin
    c_sync_d    = {c_sync_q[SYNC_STAGES-2:0], ps2c};
    d_sync_d    = {d_sync_q[SYNC_STAGES-2:0], ps2d};
    cnt_d       = '0;
    filt_d      = filt_q;
    // The filtered level flips only on the FILTER_LEN-th consecutive differing sample.
    if (c_sync != filt_q) begin
      if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
        filt_d = c_sync;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    filt_prev_d = filt_q;
    shift_d     = filt_prev_q & ~filt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      c_sync_q    <= '1;
      d_sync_q    <= '1;
      cnt_q       <= '0;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      shift_q     <= 1'b0;
    end else begin
      c_sync_q    <= c_sync_d;
      d_sync_q    <= d_sync_d;
      cnt_q       <= cnt_d;
      filt_q      <= filt_d;
      filt_prev_q <= filt_prev_d;
      shift_q     <= shift_d;
    end
  end

  assign dat   = d_sync_q[SYNC_STAGES-1];
  assign shift = shift_q;

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver with frame checking, sticky error flags and a 2**FIFO_AW byte FIFO.
// Optional mid-frame idle timeout is enabled by defining PS2_RX_TIMEOUT_EN.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_AW     = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          PS2C,
  input  logic          PS2D,
  ps2_rx_fifo_if.slave  bus
);

  localparam int DEPTH = 2 ** FIFO_AW;

  logic                  dat;
  logic                  shift;
  ps2_state_e            state_q, state_d;
  logic [2:0]            bitcnt_q, bitcnt_d;
  logic [PS2_DATA_W-1:0] sr_q, sr_d;
  logic                  par_q, par_d;
  logic [FIFO_AW:0]      wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0]      rd_ptr_q, rd_ptr_d;
  logic                  par_err_q, par_err_d;
  logic                  frm_err_q, frm_err_d;
  logic                  ovf_q, ovf_d;
  logic [PS2_DATA_W-1:0] mem_q [DEPTH];
  logic                  empty, full, push, pop;
  logic                  par_evt, frm_evt, ovf_evt;
  logic                  timeout;

  ps2_sync_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_sync_filter (
    .clk   (clk),
    .rst   (rst),
    .ps2c  (PS2C),
    .ps2d  (PS2D),
    .dat   (dat),
    .shift (shift)
  );

`ifdef PS2_RX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  always_comb begin
    timeout  = (state_q != ST_IDLE) && !shift && (to_cnt_q == TO_W'(TIMEOUT_CYC));
    to_cnt_d = to_cnt_q + 1'b1;
    if (state_q == ST_IDLE || shift || timeout) begin
      to_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  assign timeout = 1'b0;

  // A stalled frame simply waits; TIMEOUT_CYC is meaningful only in the timeout build.
  if (TIMEOUT_CYC < 1) begin : g_timeout_unused
  end
`endif

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                 (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
  assign pop   = bus.done && !empty;

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    sr_d     = sr_q;
    par_d    = par_q;
    push     = 1'b0;
    par_evt  = 1'b0;
    frm_evt  = 1'b0;
    ovf_evt  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (shift && !dat) begin
          state_d  = ST_DATA;
          bitcnt_d = '0;
        end
      end
      ST_DATA: begin
        if (shift) begin
          sr_d     = {dat, sr_q[PS2_DATA_W-1:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end
        end
      end
      ST_PARITY: begin
        if (shift) begin
          par_d   = dat;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        // A same-cycle pop frees a slot, so a full FIFO still accepts the byte.
        if (shift) begin
          state_d = ST_IDLE;
          if (!dat) begin
            frm_evt = 1'b1;
          end else if (!frame_parity_ok(sr_q, par_q)) begin
            par_evt = 1'b1;
          end else if (full && !pop) begin
            ovf_evt = 1'b1;
          end else begin
            push = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (timeout) begin
      state_d = ST_IDLE;
      frm_evt = 1'b1;
    end
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q + (FIFO_AW + 1)'(push);
    rd_ptr_d  = rd_ptr_q + (FIFO_AW + 1)'(pop);
    par_err_d = (par_err_q & ~bus.clr_err) | par_evt;
    frm_err_d = (frm_err_q & ~bus.clr_err) | frm_evt;
    ovf_d     = (ovf_q & ~bus.clr_err) | ovf_evt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      bitcnt_q  <= '0;
      sr_q      <= '0;
      par_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bitcnt_q  <= bitcnt_d;
      sr_q      <= sr_d;
      par_q     <= par_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      par_err_q <= par_err_d;
      frm_err_q <= frm_err_d;
      ovf_q     <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[FIFO_AW-1:0]] <= sr_q;
    end
  end

  assign bus.rdy     = !empty;
  assign bus.data    = mem_q[rd_ptr_q[FIFO_AW-1:0]];
  assign bus.level   = wr_ptr_q - rd_ptr_q;
  assign bus.shift   = shift;
  assign bus.par_err = par_err_q;
  assign bus.frm_err = frm_err_q;
  assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: directed and randomised PS/2 frames against a queue-based reference model.
module tb_ps2_rx_fifo;
  import ps2_pkg::*;

  localparam int AW     = 4;
  localparam int DEPTH  = 16;
  localparam int FL     = 4;
  localparam int TO_CYC = 5000;

  logic clk  = 1'b0;
  logic rst  = 1'b0;
  logic ps2c = 1'b1;
  logic ps2d = 1'b1;

  ps2_rx_fifo_if #(.FIFO_AW(AW)) bus ();

  ps2_rx_fifo #(
    .FIFO_AW     (AW),
    .SYNC_STAGES (2),
    .FILTER_LEN  (FL),
    .TIMEOUT_CYC (TO_CYC)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .PS2C (ps2c),
    .PS2D (ps2d),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int shift_cnt = 0;

  byte unsigned mq[$];
  bit m_par, m_frm, m_ovf;

  always @(negedge clk) if (bus.shift === 1'b1) shift_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // Reference: a frame either raises one error flag or lands in the queue.
  task automatic model_frame(input byte unsigned b, input bit par_ok, input bit stop_ok);
    if (!stop_ok) m_frm = 1'b1;
    else if (!par_ok) m_par = 1'b1;
    else if (mq.size() >= DEPTH) m_ovf = 1'b1;
    else mq.push_back(b);
  endtask

  task automatic check_state(input string tag);
    @(negedge clk);
    chk({tag, ".level"}, 32'(bus.level), 32'(mq.size()));
    chk({tag, ".rdy"}, 32'(bus.rdy), 32'(mq.size() != 0));
    if (mq.size() != 0) chk({tag, ".data"}, 32'(bus.data), 32'(mq[0]));
    chk({tag, ".par_err"}, 32'(bus.par_err), 32'(m_par));
    chk({tag, ".frm_err"}, 32'(bus.frm_err), 32'(m_frm));
    chk({tag, ".ovf"}, 32'(bus.ovf), 32'(m_ovf));
  endtask

  task automatic do_pop();
    @(negedge clk);
    if (mq.size() != 0) chk("pop.data", 32'(bus.data), 32'(mq[0]));
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    if (mq.size() != 0) void'(mq.pop_front());
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    m_par = 1'b0;
    m_frm = 1'b0;
    m_ovf = 1'b0;
  endtask

  // stop_mode: 0 plain, 1 check rdy timing around the stop shift, 2 pop in the stop shift cycle.
  task automatic send_frame(input byte unsigned b, input bit par_ok, input bit stop_ok,
                            input int half, input bit glitch, input int stop_mode, input string tag);
    logic [10:0] bits;
    logic        pbit;
    int          s0;
    bit          seen;
    pbit = par_ok ? ~(^b) : ^b;
    bits = {stop_ok, pbit, b, 1'b0};
    s0   = shift_cnt;
    for (int i = 0; i < 11; i++) begin
      ps2d = bits[i];
      if (glitch && i == 4) begin
        ticks(2);
        ps2c = 1'b0;
        ticks(FL - 1);
        ps2c = 1'b1;
      end
      ticks(half);
      ps2c = 1'b0;
      if (i == 10 && stop_mode != 0) begin
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
          @(negedge clk);
          if (bus.shift === 1'b1) seen = 1'b1;
        end
        chk({tag, ".stop_shift_seen"}, 32'(seen), 32'd1);
        if (stop_mode == 1) begin
          chk({tag, ".rdy_at_shift"}, 32'(bus.rdy), 32'(mq.size() != 0));
          model_frame(b, par_ok, stop_ok);
          @(negedge clk);
          chk({tag, ".rdy_next"}, 32'(bus.rdy), 32'(mq.size() != 0));
          chk({tag, ".level_next"}, 32'(bus.level), 32'(mq.size()));
        end else begin
          if (mq.size() != 0) chk({tag, ".pop_data"}, 32'(bus.data), 32'(mq[0]));
          bus.done = 1'b1;
          tick();
          bus.done = 1'b0;
          if (mq.size() != 0) void'(mq.pop_front());
          model_frame(b, par_ok, stop_ok);
        end
      end
      ticks(half);
      ps2c = 1'b1;
    end
    ticks(half);
    ps2d = 1'b1;
    if (stop_mode == 0) model_frame(b, par_ok, stop_ok);
    chk({tag, ".shifts"}, 32'(shift_cnt - s0), 32'd11);
  endtask

  task automatic send_partial(input byte unsigned b, input int nbits, input int half);
    for (int i = 0; i <= nbits; i++) begin
      ps2d = (i == 0) ? 1'b0 : b[i-1];
      ticks(half);
      ps2c = 1'b0;
      ticks(half);
      ps2c = 1'b1;
    end
    ps2d = 1'b1;
    ticks(half);
  endtask

  byte unsigned rb;
  int           kind, rhalf, npop;

  initial begin
    bus.done    = 1'b0;
    bus.clr_err = 1'b0;
    rst = 1'b0;
    ticks(5);
    check_state("reset");
    chk("reset.shift", 32'(bus.shift), 32'd0);
    rst = 1'b1;
    ticks(3);

    send_frame(8'h1C, 1'b1, 1'b1, 12, 1'b0, 1, "t1");
    check_state("t1");
    do_pop();
    check_state("t1_pop");
    do_pop();
    check_state("empty_pop");

    for (int v = 1; v <= 16; v++) send_frame(byte'(v), 1'b1, 1'b1, 10, 1'b0, 0, "t2_fill");
    check_state("t2_full");
    send_frame(8'h11, 1'b1, 1'b1, 10, 1'b0, 0, "t2_ovf");
    check_state("t2_ovf");
    for (int v = 0; v < 16; v++) do_pop();
    check_state("t2_drain");
    pulse_clr();
    check_state("t2_clr");

    send_frame(8'h55, 1'b0, 1'b1, 10, 1'b0, 0, "t3_par");
    check_state("t3_par");
    pulse_clr();
    check_state("t3_clr");
    send_frame(8'hAA, 1'b1, 1'b1, 10, 1'b0, 0, "t3_good");
    check_state("t3_good");
    do_pop();

    send_frame(8'h3C, 1'b1, 1'b0, 10, 1'b0, 0, "t4_stop");
    check_state("t4_stop");
    pulse_clr();
    send_frame(8'h96, 1'b1, 1'b1, 20, 1'b1, 0, "t4_glitch");
    check_state("t4_glitch");
    do_pop();

    for (int v = 0; v < 16; v++) send_frame(byte'($urandom), 1'b1, 1'b1, 9, 1'b0, 0, "t5_fill");
    check_state("t5_full");
    send_frame(8'hE7, 1'b1, 1'b1, 9, 1'b0, 2, "t5_pushpop");
    check_state("t5_pushpop");
    for (int v = 0; v < 16; v++) do_pop();
    check_state("t5_drain");

    send_partial(8'h5A, 5, 10);
    rst = 1'b0;
    ticks(3);
    mq.delete();
    m_par = 1'b0;
    m_frm = 1'b0;
    m_ovf = 1'b0;
    rst = 1'b1;
    ticks(2);
    check_state("rst_mid");
    send_frame(8'h3A, 1'b1, 1'b1, 10, 1'b0, 0, "t5_after_rst");
    check_state("t5_after_rst");
    do_pop();

`ifdef PS2_RX_TIMEOUT_EN
    send_partial(8'h0F, 3, 10);
    ticks(TO_CYC + 20);
    m_frm = 1'b1;
    check_state("t6_timeout");
    pulse_clr();
    send_frame(8'h29, 1'b1, 1'b1, 10, 1'b0, 0, "t6_next");
    check_state("t6_next");
    do_pop();
`endif

    for (int it = 0; it < 40; it++) begin
      rb    = byte'($urandom);
      kind  = $urandom_range(0, 9);
      rhalf = $urandom_range(8, 14);
      send_frame(rb, kind != 0, kind != 1, rhalf, 1'b0, 0, "rnd");
      check_state("rnd");
      npop = $urandom_range(0, 2);
      repeat (npop) do_pop();
      if ($urandom_range(0, 7) == 0) pulse_clr();
    end
    check_state("rnd_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
